// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC sequencer with optional return-address stack (enabled by FETCH_CTRL_RAS_EN).
// Every action lands on PC one edge after its strobe; Halt freezes everything and there are no bubbles.
module fetch_ctrl #(
    parameter int          PC_W       = 8,
    parameter int          RAS_DEPTH  = 4,
    parameter logic [31:0] START_ADDR = 32'd0
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic                        Start,
    input  logic                        Halt,
    input  logic                        Branch,
    input  logic                        Jump,
    input  logic                        Call,
    input  logic                        Ret,
    input  logic [PC_W-1:0]             Target,
    output logic [PC_W-1:0]             PC,
    output logic [$clog2(RAS_DEPTH):0]  RasCount,
    output logic                        RasFull,
    output logic                        RasEmpty,
    output logic                        RasErr
);

    localparam logic [PC_W-1:0] START_PC = START_ADDR[PC_W-1:0];

    logic [PC_W-1:0] pc_q, pc_d, pc_inc;

    assign pc_inc = pc_q + PC_W'(1);

`ifdef FETCH_CTRL_RAS_EN
    localparam int            CW       = $clog2(RAS_DEPTH) + 1;
    localparam int            AW       = $clog2(RAS_DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(RAS_DEPTH);

    // Circular buffer: top_q is the next write slot, so a push while full overwrites the oldest entry.
    logic [PC_W-1:0] stack_q [RAS_DEPTH];
    logic [AW-1:0]   top_q, top_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            push;

    always_comb begin
        pc_d  = pc_q;
        top_d = top_q;
        cnt_d = cnt_q;
        err_d = err_q;
        push  = 1'b0;
        if (Start) begin
            pc_d  = START_PC;
            top_d = '0;
            cnt_d = '0;
            err_d = 1'b0;
        end else if (!Halt) begin
            if (Ret) begin
                if (cnt_q == '0) begin
                    pc_d  = pc_inc;
                    err_d = 1'b1;
                end else begin
                    pc_d  = stack_q[top_q - AW'(1)];
                    top_d = top_q - AW'(1);
                    cnt_d = cnt_q - CW'(1);
                end
            end else if (Call) begin
                push  = 1'b1;
                pc_d  = Target;
                top_d = top_q + AW'(1);
                if (cnt_q == FULL_CNT) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end else if (Jump) begin
                pc_d = Target;
            end else if (Branch) begin
                pc_d = pc_q + Target;
            end else begin
                pc_d = pc_inc;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            top_q <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            top_q <= top_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
            if (push) begin
                stack_q[top_q] <= pc_inc;
            end
        end
    end

    assign RasCount = cnt_q;
    assign RasFull  = (cnt_q == FULL_CNT);
    assign RasEmpty = (cnt_q == '0);
    assign RasErr   = err_q;
`else
    // Without the stack, Call degenerates to Jump and Ret to a plain increment.
    always_comb begin
        pc_d = pc_q;
        if (Start) begin
            pc_d = START_PC;
        end else if (!Halt) begin
            if (Ret) begin
                pc_d = pc_inc;
            end else if (Call || Jump) begin
                pc_d = Target;
            end else if (Branch) begin
                pc_d = pc_q + Target;
            end else begin
                pc_d = pc_inc;
            end
        end
    end

    assign RasCount = '0;
    assign RasFull  = 1'b0;
    assign RasEmpty = 1'b1;
    assign RasErr   = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pc_q <= START_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign PC = pc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: queue-based reference model checked every falling edge,
// plus directed sequences with literal expectations for both stack-enabled and stack-less builds.
module tb_fetch_ctrl;

    localparam int PC_W  = 8;
    localparam int DEPTH = 4;
    localparam int MASK  = 255;
    localparam int START = 0;
`ifdef FETCH_CTRL_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif

    logic            CLK    = 1'b0;
    logic            RST_N  = 1'b0;
    logic            Start  = 1'b0;
    logic            Halt   = 1'b0;
    logic            Branch = 1'b0;
    logic            Jump   = 1'b0;
    logic            Call   = 1'b0;
    logic            Ret    = 1'b0;
    logic [PC_W-1:0] Target = '0;
    logic [PC_W-1:0] PC;
    logic [2:0]      RasCount;
    logic            RasFull, RasEmpty, RasErr;

    int checks = 0;
    int errs   = 0;
    bit chk_en = 1'b0;

    int m_pc  = START;
    int m_ras[$];
    bit m_err = 1'b0;

    fetch_ctrl #(.PC_W(PC_W), .RAS_DEPTH(DEPTH), .START_ADDR(32'd0)) dut (
        .CLK(CLK), .RST_N(RST_N), .Start(Start), .Halt(Halt), .Branch(Branch),
        .Jump(Jump), .Call(Call), .Ret(Ret), .Target(Target), .PC(PC),
        .RasCount(RasCount), .RasFull(RasFull), .RasEmpty(RasEmpty), .RasErr(RasErr)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: stack is a queue with the newest entry at the back.
    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m_pc  = START;
            m_err = 1'b0;
            m_ras.delete();
        end else if (Start) begin
            m_pc  = START;
            m_err = 1'b0;
            m_ras.delete();
        end else if (Halt) begin
            m_pc = m_pc;
        end else if (Ret) begin
            if (!RAS_EN) begin
                m_pc = (m_pc + 1) & MASK;
            end else if (m_ras.size() == 0) begin
                m_pc  = (m_pc + 1) & MASK;
                m_err = 1'b1;
            end else begin
                m_pc = m_ras.pop_back();
            end
        end else if (Call) begin
            if (RAS_EN) begin
                if (m_ras.size() == DEPTH) begin
                    void'(m_ras.pop_front());
                    m_err = 1'b1;
                end
                m_ras.push_back((m_pc + 1) & MASK);
            end
            m_pc = int'(Target);
        end else if (Jump) begin
            m_pc = int'(Target);
        end else if (Branch) begin
            m_pc = (m_pc + int'($signed(Target))) & MASK;
        end else begin
            m_pc = (m_pc + 1) & MASK;
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("model_pc", PC, m_pc);
            chk("model_cnt", RasCount, m_ras.size());
            chk("model_full", RasFull, int'(m_ras.size() == DEPTH));
            chk("model_empty", RasEmpty, int'(m_ras.size() == 0));
            chk("model_err", RasErr, int'(m_err));
        end
    end

    task automatic step(input logic s, input logic h, input logic r, input logic c,
                        input logic j, input logic b, input logic [PC_W-1:0] t);
        Start = s; Halt = h; Ret = r; Call = c; Jump = j; Branch = b; Target = t;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] exp_ret[4];

        #12;
        chk("rst_pc", PC, 0);
        chk("rst_cnt", RasCount, 0);
        chk("rst_empty", RasEmpty, 1);
        chk("rst_full", RasFull, 0);
        chk("rst_err", RasErr, 0);
        RST_N  = 1'b1;
        chk_en = 1'b1;

        for (int i = 1; i <= 5; i++) begin
            idle();
            chk("inc_pc", PC, i);
        end

        step(0, 0, 0, 0, 1, 0, 8'hFF);
        chk("jump_ff", PC, 8'hFF);
        idle();
        chk("wrap_pc", PC, 8'h00);

        step(0, 0, 0, 0, 1, 0, 8'h10);
        step(0, 0, 0, 0, 0, 1, 8'hFC);
        chk("branch_neg", PC, 8'h0C);
        step(0, 0, 0, 0, 0, 1, 8'h05);
        chk("branch_pos", PC, 8'h11);

        step(0, 0, 0, 0, 1, 0, 8'h20);
        step(0, 0, 0, 1, 0, 0, 8'h40);
        chk("call1_pc", PC, 8'h40);
        chk("call1_cnt", RasCount, RAS_EN ? 1 : 0);
        idle();
        chk("after_call_pc", PC, 8'h41);
        step(0, 0, 0, 1, 0, 0, 8'h60);
        chk("call2_pc", PC, 8'h60);
        chk("call2_cnt", RasCount, RAS_EN ? 2 : 0);
        step(0, 0, 1, 0, 0, 0, 8'h00);
        chk("ret1_pc", PC, RAS_EN ? 8'h42 : 8'h61);
        chk("ret1_cnt", RasCount, RAS_EN ? 1 : 0);
        step(0, 0, 1, 0, 0, 0, 8'h00);
        chk("ret2_pc", PC, RAS_EN ? 8'h21 : 8'h62);
        chk("ret2_cnt", RasCount, 0);

        step(1, 0, 0, 0, 0, 0, 8'h00);
        chk("start_pc", PC, 0);
        for (int k = 0; k < 5; k++) begin
            step(0, 0, 0, 1, 0, 0, 8'(8'h80 + 16 * k));
        end
        chk("ovf_pc", PC, 8'hC0);
        chk("ovf_full", RasFull, RAS_EN ? 1 : 0);
        chk("ovf_err", RasErr, RAS_EN ? 1 : 0);
        chk("ovf_cnt", RasCount, RAS_EN ? 4 : 0);
        exp_ret = RAS_EN ? '{8'hB1, 8'hA1, 8'h91, 8'h81} : '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 1, 0, 0, 0, 8'h00);
            chk("ovf_ret_pc", PC, exp_ret[k]);
        end
        step(0, 0, 1, 0, 0, 0, 8'h00);
        chk("unf_pc", PC, RAS_EN ? 8'h82 : 8'hC5);
        chk("unf_err", RasErr, RAS_EN ? 1 : 0);
        chk("unf_cnt", RasCount, 0);
        chk("unf_empty", RasEmpty, 1);

        step(1, 1, 1, 0, 0, 1, 8'h05);
        chk("prio_start_pc", PC, 0);
        chk("prio_start_cnt", RasCount, 0);
        chk("prio_start_err", RasErr, 0);
        step(0, 0, 0, 1, 0, 0, 8'h30);
        chk("call30_pc", PC, 8'h30);
        step(0, 1, 0, 1, 0, 0, 8'h77);
        chk("halt_pc", PC, 8'h30);
        chk("halt_cnt", RasCount, RAS_EN ? 1 : 0);
        step(0, 0, 1, 1, 1, 0, 8'h77);
        chk("ret_over_call_pc", PC, RAS_EN ? 8'h01 : 8'h31);
        chk("ret_over_call_cnt", RasCount, 0);
        step(0, 0, 0, 0, 1, 1, 8'h44);
        chk("jump_over_branch", PC, 8'h44);

        step(0, 0, 0, 1, 0, 0, 8'h50);
        chk("call50_pc", PC, 8'h50);
        Call   = 1'b1;
        Target = 8'h55;
        #1;
        RST_N = 1'b0;
        #1;
        chk("async_rst_pc", PC, 0);
        chk("async_rst_cnt", RasCount, 0);
        chk("async_rst_empty", RasEmpty, 1);
        #1;
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        chk("post_rst_call_pc", PC, 8'h55);
        chk("post_rst_call_cnt", RasCount, RAS_EN ? 1 : 0);
        idle();
        chk("post_rst_inc", PC, 8'h56);
        idle();
        @(negedge CLK);
        #1;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
